// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch direction predictor.
// One-cycle registered lookup, one-cycle training from resolved branches,
// registered mispredict pulse and saturating hit/miss statistics.
// Optional feature: define BP_GSHARE_EN to XOR the table index with a global
// history register (gshare); undefined gives a plain bimodal predictor.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_out_valid,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic        res_pred,
    output logic        mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned STAT_W = 32;

    logic [1:0]        cnt_q [ENTRIES];
    logic [1:0]        cnt_d [ENTRIES];
    logic [IDX_W-1:0]  pidx_c;
    logic [IDX_W-1:0]  ridx_c;
    logic              pred_out_valid_q, pred_out_valid_d;
    logic              pred_taken_q,     pred_taken_d;
    logic              mispredict_q,     mispredict_d;
    logic [STAT_W-1:0] branches_q,       branches_d;
    logic [STAT_W-1:0] mispred_q,        mispred_d;
    logic              unused_c;

    // PC bits outside the index (and bit 0, always zero with RVC) do not matter
    assign unused_c = ^{pred_pc[31:IDX_W+1], pred_pc[0], res_pc[31:IDX_W+1], res_pc[0]};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    // Gshare index: both ports use the history from before the current edge
    assign pidx_c = pred_pc[IDX_W:1] ^ ghr_q;
    assign ridx_c = res_pc[IDX_W:1]  ^ ghr_q;

    // Shift each resolved outcome into the global history
    always_comb begin
        ghr_d = ghr_q;
        if (res_valid) begin
            ghr_d = {ghr_q[IDX_W-2:0], res_taken};
        end
    end

    // History register
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    // Bimodal index straight from the halfword-aligned PC
    assign pidx_c = pred_pc[IDX_W:1];
    assign ridx_c = res_pc[IDX_W:1];
`endif

    // Counter training: saturating increment on taken, decrement on not-taken
    always_comb begin
        cnt_d = cnt_q;
        if (res_valid) begin
            if (res_taken) begin
                if (cnt_q[ridx_c] != 2'b11) begin
                    cnt_d[ridx_c] = cnt_q[ridx_c] + 2'b01;
                end
            end else begin
                if (cnt_q[ridx_c] != 2'b00) begin
                    cnt_d[ridx_c] = cnt_q[ridx_c] - 2'b01;
                end
            end
        end
    end

    // Lookup, mispredict and statistics next-state; lookup reads pre-update table
    always_comb begin
        pred_out_valid_d = pred_valid;
        pred_taken_d     = pred_taken_q;
        mispredict_d     = res_valid & (res_taken ^ res_pred);
        branches_d       = branches_q;
        mispred_d        = mispred_q;
        if (pred_valid) begin
            pred_taken_d = cnt_q[pidx_c][1];
        end
        if (res_valid && (branches_q != '1)) begin
            branches_d = branches_q + STAT_W'(1);
        end
        if (mispredict_d && (mispred_q != '1)) begin
            mispred_d = mispred_q + STAT_W'(1);
        end
    end

    // State registers; reset returns every counter to weak not-taken
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= 2'b01;
            end
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            mispredict_q     <= 1'b0;
            branches_q       <= '0;
            mispred_q        <= '0;
        end else begin
            cnt_q            <= cnt_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            mispredict_q     <= mispredict_d;
            branches_q       <= branches_d;
            mispred_q        <= mispred_d;
        end
    end

    assign pred_out_valid = pred_out_valid_q;
    assign pred_taken     = pred_taken_q;
    assign mispredict     = mispredict_q;
    assign stat_branches  = branches_q;
    assign stat_mispred   = mispred_q;

endmodule
